// File: rtl/inv_rns.sv
// Residue-to-double converter: centres each residue mod q, scales by 2^-scale, writes binary64.
// Optional build macro INV_RNS_RANGE_CHECK_EN replaces residues x >= q with quiet NaN.
module inv_rns #(
    parameter int unsigned LOGN = 13,
    parameter int unsigned LOGQ = 54
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      current_n,
    input  logic [LOGQ-1:0] q,
    input  logic [10:0]     scale,
    output logic [LOGN-1:0] bram_rd_addr,
    input  logic [LOGQ-1:0] bram_rd_data,
    output logic [LOGN-1:0] bram_wr_addr,
    output logic [63:0]     bram_wr_data,
    output logic            bram_wea,
    output logic            busy,
    output logic            done,
    output logic            range_err
);

    localparam int unsigned MW = (LOGQ > 53) ? LOGQ : 53;
    localparam logic [63:0] QNAN = 64'h7FF8000000000000;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t          state, state_d;
    logic [LOGN-1:0] addr_d, last_c, last_r;
    logic [LOGQ-1:0] q_r;
    logic [10:0]     scale_r;
    logic            accept;

    // Two-cycle BRAM latency: valid and address ride alongside the read.
    logic [1:0]      rv;
    logic [LOGN-1:0] ra1, ra2;

    logic            s1_v, s1_sign, s1_nan;
    logic [LOGN-1:0] s1_addr;
    logic [LOGQ-1:0] s1_mag;

    logic            s2_v, s2_sign, s2_nan, s2_zero;
    logic [LOGN-1:0] s2_addr;
    logic [10:0]     s2_exp;
    logic [51:0]     s2_man;

    int              logsz;
    always_comb begin
        case (current_n)
            2'd0:    logsz = 13;
            2'd1:    logsz = 14;
            default: logsz = 15;
        endcase
        // Bits below log2(N) set; saturates to all-ones when N exceeds 2^LOGN.
        last_c = '0;
        for (int i = 0; i < LOGN; i++) last_c[i] = (i < logsz);
    end

    always_comb begin
        state_d = state;
        addr_d  = bram_rd_addr;
        accept  = 1'b0;
        done    = 1'b0;
        case (state)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                    addr_d  = '0;
                end
            end
            StRun: begin
                if (bram_rd_addr == last_r) begin
                    state_d = StDrain;
                    addr_d  = '0;
                end else begin
                    addr_d = bram_rd_addr + 1'b1;
                end
            end
            StDrain: begin
                if (!(|rv || s1_v || s2_v || bram_wea)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            bram_rd_addr <= '0;
            q_r          <= '0;
            scale_r      <= '0;
            last_r       <= '0;
        end else begin
            state        <= state_d;
            bram_rd_addr <= addr_d;
            if (accept) begin
                q_r     <= q;
                scale_r <= scale;
                last_r  <= last_c;
            end
        end
    end

    // Stage 1: centre the residue into sign/magnitude.
    logic [LOGQ:0]   half_c;
    logic            neg_c, nan_c;
    logic [LOGQ-1:0] mag_c;
    always_comb begin
        half_c = ({1'b0, q_r} + (LOGQ+1)'(1)) >> 1;
        neg_c  = ({1'b0, bram_rd_data} >= half_c);
        mag_c  = neg_c ? (q_r - bram_rd_data) : bram_rd_data;
`ifdef INV_RNS_RANGE_CHECK_EN
        nan_c  = (bram_rd_data >= q_r);
`else
        nan_c  = 1'b0;
`endif
    end

    // Stage 2: leading-one detect, normalise, biased exponent with underflow flush.
    logic [7:0]        p_c, shamt_c;
    logic [MW-1:0]     mag_ext;
    logic [51:0]       man_c;
    logic signed [13:0] exp_c;
    logic              zero_c;
    always_comb begin
        p_c = '0;
        for (int i = 0; i < LOGQ; i++) begin
            if (s1_mag[i]) p_c = 8'(i);
        end
        mag_ext = MW'(s1_mag);
        shamt_c = 8'(MW - 1) - p_c;
        man_c   = 52'((mag_ext << shamt_c) >> (MW - 53));
        exp_c   = 14'sd1023 + $signed({6'd0, p_c}) - $signed({3'd0, scale_r});
        zero_c  = (s1_mag == '0) || (exp_c <= 14'sd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv           <= '0;
            ra1          <= '0;
            ra2          <= '0;
            s1_v         <= 1'b0;
            s1_sign      <= 1'b0;
            s1_nan       <= 1'b0;
            s1_addr      <= '0;
            s1_mag       <= '0;
            s2_v         <= 1'b0;
            s2_sign      <= 1'b0;
            s2_nan       <= 1'b0;
            s2_zero      <= 1'b0;
            s2_addr      <= '0;
            s2_exp       <= '0;
            s2_man       <= '0;
            bram_wea     <= 1'b0;
            bram_wr_addr <= '0;
            bram_wr_data <= '0;
        end else begin
            rv           <= {rv[0], state == StRun};
            ra1          <= bram_rd_addr;
            ra2          <= ra1;
            s1_v         <= rv[1];
            s1_sign      <= neg_c;
            s1_nan       <= nan_c;
            s1_addr      <= ra2;
            s1_mag       <= mag_c;
            s2_v         <= s1_v;
            s2_sign      <= s1_sign;
            s2_nan       <= s1_nan;
            s2_zero      <= zero_c;
            s2_addr      <= s1_addr;
            s2_exp       <= exp_c[10:0];
            s2_man       <= man_c;
            bram_wea     <= s2_v;
            bram_wr_addr <= s2_addr;
            if (s2_nan)       bram_wr_data <= QNAN;
            else if (s2_zero) bram_wr_data <= '0;
            else              bram_wr_data <= {s2_sign, s2_exp, s2_man};
        end
    end

`ifdef INV_RNS_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                range_err <= 1'b0;
        else if (accept)           range_err <= 1'b0;
        else if (s2_v && s2_nan)   range_err <= 1'b1;
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: doc/inv_rns.md
INV_RNS -- requirements
Module: inv_rns

Interface
REQ-001 The block SHALL have parameter LOGN, default 13, the maximum polynomial address width.
REQ-002 The block SHALL have parameter LOGQ, default 54, the residue and modulus width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: one-cycle request to begin a conversion.
REQ-006 Port current_n, input, 2 bits: polynomial size select; 0 selects 8192 coefficients, 1 selects 16384, 2 or 3 selects 32768; the value SHALL be clamped to 2^LOGN.
REQ-007 Port q, input, LOGQ bits: odd modulus.
REQ-008 Port scale, input, 11 bits: unsigned power-of-two divisor exponent.
REQ-009 Port bram_rd_addr, output, LOGN bits: residue BRAM read address.
REQ-010 Port bram_rd_data, input, LOGQ bits: residue word, available 2 cycles after its address.
REQ-011 Port bram_wr_addr, output, LOGN bits: FFT BRAM write address.
REQ-012 Port bram_wr_data, output, 64 bits: IEEE-754 binary64 result.
REQ-013 Port bram_wea, output, 1 bit: FFT BRAM write enable.
REQ-014 Port busy, output, 1 bit: high while a conversion is active.
REQ-015 Port done, output, 1 bit: one-cycle completion pulse.
REQ-016 Port range_err, output, 1 bit: sticky out-of-range flag.

Function
REQ-017 States SHALL be IDLE, RUN, DRAIN.
- IDLE to RUN: on start; q, scale and current_n are latched that cycle.
- RUN to DRAIN: after address N-1 has been issued.
- DRAIN to IDLE: after the last write; done pulses in the same cycle as the transition.
REQ-018 start while busy SHALL be ignored, and the latched values SHALL not change.
REQ-019 Address generation in RUN: bram_rd_addr SHALL start at 0 and increment by 1 every cycle up to N-1, one address per cycle, with no stalls.
REQ-020 Centering: for each residue x, if x >= (q+1)/2 then sign=1 and mag=q-x; otherwise sign=0 and mag=x.
REQ-021 Normalization: a leading-one detector SHALL find the position p of the top set bit of mag (p <= 52 for legal q).
- Mantissa = bits [51:0] of (mag << (52-p)).
- Exponent = 1023 + p - scale, computed signed with at least 13 bits.
REQ-022 The output SHALL be {sign, exponent[10:0], mantissa}.
REQ-023 If mag == 0, or the computed exponent <= 0, the output SHALL be 64'h0 (flush to +0, sign cleared).
REQ-024 The pipeline SHALL have exactly 3 register stages after BRAM data arrives.
- bram_wea and bram_wr_addr are asserted exactly 5 cycles after the corresponding bram_rd_addr.
- The write order is identical to the read order.
REQ-025 Throughput SHALL be one coefficient per cycle; bram_wea SHALL be high for exactly N consecutive cycles per conversion.
REQ-026 busy SHALL be high from the cycle after start is accepted through the done cycle.
REQ-027 done SHALL occur 1 cycle after the last bram_wea.
REQ-028 bram_rd_addr SHALL hold 0 when not in RUN; bram_wr_addr and bram_wr_data SHALL be don't-care when bram_wea is low.

Reset
REQ-029 When rst_n is low, the following SHALL be forced immediately, independent of clk: state=IDLE, address counter=0, all pipeline valid bits=0, bram_wea=0, busy=0, done=0, range_err=0, bram_wr_addr=0, bram_wr_data=0.
REQ-030 Reset asserted mid-conversion SHALL abort the conversion: no further writes, no done pulse.
REQ-031 After rst_n deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-032 Macro INV_RNS_RANGE_CHECK_EN controls out-of-range checking of residues (x >= q).
- Defined: each x >= q writes quiet NaN 64'h7FF8000000000000 in its slot and sets range_err; range_err clears only on accepted start or on reset.
- Undefined: no check is made; range_err is tied to 0; x is processed per REQ-020 with subtraction modulo 2^LOGQ.

Verification
REQ-033 q=97, scale=0, x=1 -> bram_wr_data=64'h3FF0000000000000 (+1.0).
REQ-034 q=97, scale=0, x=96 -> 64'hBFF0000000000000 (-1.0); x=48 -> 64'h4048000000000000; x=49 -> 64'hC048000000000000.
REQ-035 q=97, x=0 -> 64'h0.
- scale=1, x=1 -> 64'h3FE0000000000000.
- scale=1100, x=1 -> 64'h0 (flush to zero).
REQ-036 current_n=0, with start pulsed at cycle 0:
- addresses 0..8191 issued from cycle 1;
- bram_wea high for 8192 cycles starting at cycle 6;
- done at cycle 8198;
- a second start at cycle 100 is ignored.
REQ-037 rst_n driven low at coefficient 4000 -> bram_wea, busy, done all 0 at once; a new start after release converts from address 0.
REQ-038 With INV_RNS_RANGE_CHECK_EN defined, q=97, x=200 at address 5 -> address 5 gets 64'h7FF8000000000000 and range_err=1 until the next start; with the macro undefined, range_err stays 0.
